// File: rtl/uart_tx_fifo_if.sv
// Bus-side and serializer-side signals of the UART transmit FIFO.
// The slave modport is the FIFO; master is the CPU/serializer environment.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              flush;
  logic              clr_ovf;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              tx_idle;

  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, tx_ready,
    output tx_data, tx_valid, count, full, empty, overflow, tx_idle
  );

  modport master (
    output wr_en, wr_data, flush, clr_ovf, tx_ready,
    input  tx_data, tx_valid, count, full, empty, overflow, tx_idle
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART serializer, with
// level, sticky overflow and drain status for the UART status register.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full, empty, push, drop, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // full is taken from the pre-edge count, so a pop never makes room for a same-cycle push
  assign push  = bus.wr_en &  ~full & ~bus.flush;
  assign drop  = bus.wr_en &   full & ~bus.flush;
  assign pop   = ~empty & bus.tx_ready & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop)             ovf_d = 1'b1;
      else if (bus.clr_ovf) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; contents behind rd_ptr are never observed.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.tx_data  = mem_q[rd_ptr_q];
  assign bus.tx_valid = ~empty;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = ovf_q;
  assign bus.tx_idle  = empty & bus.tx_ready;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, a serial line model, random traffic.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(4)) bus();
  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Serializer model: 4 clocks per bit, start + 8 data LSB first + stop.
  logic       ser_en = 1'b0;
  logic       ser_busy = 1'b0;
  int         ser_cnt = 0;
  logic [9:0] ser_sh = '1;
  logic       line = 1'b1;
  logic       rdy_drv = 1'b0;
  assign bus.tx_ready = ser_en ? ~ser_busy : rdy_drv;

  always @(posedge clk) begin
    if (!ser_en) begin
      ser_busy <= 1'b0;
      line     <= 1'b1;
    end else if (!ser_busy) begin
      if (bus.tx_valid && bus.tx_ready) begin
        ser_sh   <= {1'b1, bus.tx_data, 1'b0};
        ser_busy <= 1'b1;
        ser_cnt  <= 0;
      end
    end else begin
      ser_cnt <= ser_cnt + 1;
      line    <= ser_sh[ser_cnt/4];
      if (ser_cnt == 39) ser_busy <= 1'b0;
    end
  end

  // Line receiver: samples mid-bit after a falling start edge.
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rxq[$];
  always @(negedge clk) begin
    if (!rx_busy) begin
      if (ser_en && line == 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 5 && rx_cnt <= 33 && (rx_cnt % 4) == 1)
        rx_sh[(rx_cnt - 5) / 4] <= line;
      if (rx_cnt == 37) begin
        rxq.push_back(rx_sh);
        rx_busy <= 1'b0;
      end
    end
  end

  // Reference model: a byte queue plus a sticky flag.
  logic [7:0] mq[$];
  logic       movf = 1'b0;
  initial forever begin
    @(posedge clk);
    if (reset || bus.flush) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      automatic bit was_full = (mq.size() == 16);
      automatic bit m_pop    = (mq.size() > 0) && bus.tx_ready;
      if (m_pop) void'(mq.pop_front());
      if (bus.wr_en && !was_full) mq.push_back(bus.wr_data);
      if (bus.wr_en && was_full) movf = 1'b1;
      else if (bus.clr_ovf)      movf = 1'b0;
    end
  end

  bit chk_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("count",    32'(bus.count),    32'(mq.size()));
      chk("tx_valid", 32'(bus.tx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(mq[0]));
      chk("full",     32'(bus.full),     32'(mq.size() == 16));
      chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
      chk("overflow", 32'(bus.overflow), 32'(movf));
      chk("tx_idle",  32'(bus.tx_idle),  32'((mq.size() == 0) && bus.tx_ready));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_en = 1'b0; bus.flush = 1'b0; bus.clr_ovf = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = base + 8'(i);
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rdy_drv = 1'b1;
    bus.wr_data = '0;
    idle_in();
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_valid", 32'(bus.tx_valid), 0);
    chk("rst_ovf",   32'(bus.overflow), 0);
    chk("rst_idle",  32'(bus.tx_idle), 1);

    // Single write, then one accepting cycle
    rdy_drv = 1'b0;
    push_n(1, 8'h41);
    chk("sw_valid", 32'(bus.tx_valid), 1);
    chk("sw_data",  32'(bus.tx_data), 32'h41);
    chk("sw_count", 32'(bus.count), 1);
    rdy_drv = 1'b1; step(); rdy_drv = 1'b0;
    chk("sw_count0", 32'(bus.count), 0);
    chk("sw_valid0", 32'(bus.tx_valid), 0);

    // Fill past capacity, then drain in order
    push_n(17, 8'h00);
    chk("fill_count", 32'(bus.count), 16);
    chk("fill_full",  32'(bus.full), 1);
    chk("fill_ovf",   32'(bus.overflow), 1);
    rdy_drv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(bus.tx_data), 32'(i));
      step();
    end
    rdy_drv = 1'b0;
    chk("drain_empty", 32'(bus.empty), 1);
    bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 0);

    // Simultaneous push and pop at count 5 and at full
    push_n(5, 8'h20);
    bus.wr_en = 1'b1; bus.wr_data = 8'h25; rdy_drv = 1'b1; step();
    bus.wr_en = 1'b0; rdy_drv = 1'b0;
    chk("pp5_count", 32'(bus.count), 5);
    chk("pp5_head",  32'(bus.tx_data), 32'h21);
    push_n(11, 8'h30);
    chk("pp16_pre", 32'(bus.count), 16);
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE; rdy_drv = 1'b1; step();
    bus.wr_en = 1'b0; rdy_drv = 1'b0;
    chk("pp16_count", 32'(bus.count), 15);
    chk("pp16_ovf",   32'(bus.overflow), 1);

    // Flush colliding with a push at count 7, overflow set
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    push_n(17, 8'h60);
    rdy_drv = 1'b1;
    for (int i = 0; i < 9; i++) step();
    rdy_drv = 1'b0;
    chk("fc_count7", 32'(bus.count), 7);
    chk("fc_ovf1",   32'(bus.overflow), 1);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE; step();
    idle_in();
    chk("fc_count", 32'(bus.count), 0);
    chk("fc_empty", 32'(bus.empty), 1);
    chk("fc_ovf",   32'(bus.overflow), 0);
    push_n(1, 8'h55);
    chk("fc_data",  32'(bus.tx_data), 32'h55);
    bus.flush = 1'b1; step(); bus.flush = 1'b0;

    // Wrap-around stream through the serializer model
    ser_en = 1'b1;
    begin
      int sent = 0;
      int budget = 4000;
      while ((rxq.size() < 40 || ser_busy || !bus.empty) && budget > 0) begin
        if (sent < 40 && !bus.full) begin
          bus.wr_en = 1'b1; bus.wr_data = 8'h80 + 8'(sent); sent++;
        end else bus.wr_en = 1'b0;
        step();
        budget--;
      end
      bus.wr_en = 1'b0;
      chk("stream_timeout", 32'(budget > 0), 1);
      chk("stream_len", 32'(rxq.size()), 40);
      for (int i = 0; i < 40 && i < rxq.size(); i++)
        chk("stream_byte", 32'(rxq[i]), 32'h80 + 32'(i));
      chk("stream_idle", 32'(bus.tx_idle), 1);
    end
    ser_en = 1'b0;
    step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.wr_en   = ($urandom_range(0, 99) < 55);
      bus.wr_data = 8'($urandom);
      rdy_drv     = ($urandom_range(0, 99) < 40);
      bus.flush   = ($urandom_range(0, 199) == 0);
      bus.clr_ovf = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_in();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
